// File: rtl/memory_lsu_stage.sv
// rtl/memory_lsu_stage.sv - rvga memory stage: dcache loads/stores with lane masking, plus ALU passthrough
// Define RVGA_MEM_MISALIGN_TRAP_EN to report misaligned accesses instead of issuing them.
module memory_lsu_stage #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mem_valid,
  output logic              ex_mem_ready,
  input  logic [1:0]        ex_mem_op,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_unsigned,
  input  logic [XLEN-1:0]   ex_mem_addr,
  input  logic [XLEN-1:0]   ex_mem_wdata,
  input  logic [XLEN-1:0]   ex_mem_result,
  input  logic [4:0]        ex_mem_rd,
  output logic [XLEN-1:0]   memory_dcache_addr,
  output logic              memory_dcache_read,
  output logic              memory_dcache_write,
  output logic [XLEN-1:0]   memory_dcache_wdata,
  output logic [XLEN/8-1:0] memory_dcache_wmask,
  input  logic [XLEN-1:0]   dcache_memory_rdata,
  input  logic              dcache_memory_resp,
  output logic              mem_wb_valid,
  input  logic              mem_wb_ready,
  output logic [4:0]        mem_wb_rd,
  output logic [XLEN-1:0]   mem_wb_data,
  output logic              mem_wb_we,
  output logic              mem_wb_misaligned
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] dc_addr_q, dc_addr_d, dc_wdata_q, dc_wdata_d;
  logic [NB-1:0]   dc_wmask_q, dc_wmask_d;
  logic            dc_read_q, dc_read_d, dc_write_q, dc_write_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [4:0]      prd_q, prd_d;
  logic            wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic            accept, is_mem;
  logic [OFFW-1:0] off;
  int              bytes_in, bytes_q;
  logic [NB-1:0]   wmask;
  logic [XLEN-1:0] shifted, low_mask, load_ext;
  logic            sign_bit;

  assign ex_mem_ready = (state_q == IDLE) && (!wb_valid_q || mem_wb_ready);
  assign accept       = ex_mem_valid && ex_mem_ready;
  assign is_mem       = (ex_mem_op == 2'b01) || (ex_mem_op == 2'b10);
  assign off          = ex_mem_addr[OFFW-1:0];

  // Lanes past the aligned word simply fall off the mask and the shifts.
  always_comb begin
    bytes_in = 1 << ex_mem_size;
    bytes_q  = 1 << size_q;
    for (int b = 0; b < NB; b++) begin
      wmask[b] = (b >= int'(off)) && (b < int'(off) + bytes_in);
    end
    shifted  = dcache_memory_rdata >> {off_q, 3'b000};
    low_mask = '0;
    sign_bit = 1'b0;
    for (int b = 0; b < XLEN; b++) begin
      low_mask[b] = (b < 8 * bytes_q);
      if (b == 8 * bytes_q - 1) sign_bit = shifted[b];
    end
    load_ext = shifted & low_mask;
    if (!uns_q && sign_bit && bytes_q < NB) load_ext = load_ext | ~low_mask;
  end

`ifdef RVGA_MEM_MISALIGN_TRAP_EN
  logic wb_mis_q, wb_mis_d, misal;
  assign misal = (ex_mem_size == 2'b11 && XLEN == 32) || ((int'(off) % bytes_in) != 0);
  assign mem_wb_misaligned = wb_mis_q;
`else
  assign mem_wb_misaligned = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dc_addr_d  = dc_addr_q;
    dc_wdata_d = dc_wdata_q;
    dc_wmask_d = dc_wmask_q;
    dc_read_d  = dc_read_q;
    dc_write_d = dc_write_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    prd_d      = prd_q;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_we_d    = wb_we_q;
`ifdef RVGA_MEM_MISALIGN_TRAP_EN
    wb_mis_d   = wb_mis_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_mem_rd;
            wb_data_d  = ex_mem_result;
            wb_we_d    = (ex_mem_rd != 5'd0);
`ifdef RVGA_MEM_MISALIGN_TRAP_EN
            wb_mis_d   = 1'b0;
          end else if (misal) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_mem_rd;
            wb_data_d  = ex_mem_addr;
            wb_we_d    = 1'b0;
            wb_mis_d   = 1'b1;
`endif
          end else begin
            state_d    = ACCESS;
            wb_valid_d = 1'b0;
            dc_addr_d  = {ex_mem_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            dc_wdata_d = ex_mem_wdata << {off, 3'b000};
            dc_wmask_d = (ex_mem_op == 2'b10) ? wmask : '0;
            dc_read_d  = (ex_mem_op == 2'b01);
            dc_write_d = (ex_mem_op == 2'b10);
            off_d      = off;
            size_d     = ex_mem_size;
            uns_d      = ex_mem_unsigned;
            prd_d      = ex_mem_rd;
          end
        end else if (mem_wb_ready) begin
          wb_valid_d = 1'b0;
        end
      end
      ACCESS: begin
        if (dcache_memory_resp) begin
          state_d    = IDLE;
          dc_read_d  = 1'b0;
          dc_write_d = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = prd_q;
          wb_data_d  = dc_read_q ? load_ext : '0;
          wb_we_d    = dc_read_q && (prd_q != 5'd0);
`ifdef RVGA_MEM_MISALIGN_TRAP_EN
          wb_mis_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dc_addr_q  <= '0;
      dc_wdata_q <= '0;
      dc_wmask_q <= '0;
      dc_read_q  <= 1'b0;
      dc_write_q <= 1'b0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      prd_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_we_q    <= 1'b0;
`ifdef RVGA_MEM_MISALIGN_TRAP_EN
      wb_mis_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dc_addr_q  <= dc_addr_d;
      dc_wdata_q <= dc_wdata_d;
      dc_wmask_q <= dc_wmask_d;
      dc_read_q  <= dc_read_d;
      dc_write_q <= dc_write_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      prd_q      <= prd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_we_q    <= wb_we_d;
`ifdef RVGA_MEM_MISALIGN_TRAP_EN
      wb_mis_q   <= wb_mis_d;
`endif
    end
  end

  assign memory_dcache_addr  = dc_addr_q;
  assign memory_dcache_wdata = dc_wdata_q;
  assign memory_dcache_wmask = dc_wmask_q;
  assign memory_dcache_read  = dc_read_q;
  assign memory_dcache_write = dc_write_q;
  assign mem_wb_valid        = wb_valid_q;
  assign mem_wb_rd           = wb_rd_q;
  assign mem_wb_data         = wb_data_q;
  assign mem_wb_we           = wb_we_q;
endmodule

// File: tb/tb_memory_lsu_stage.sv
// tb/tb_memory_lsu_stage.sv - randomized scoreboard bench for memory_lsu_stage (XLEN=32)
module tb_memory_lsu_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_mem_valid = 1'b0, ex_mem_ready, ex_mem_unsigned = 1'b0;
  logic [1:0]  ex_mem_op = 2'd0, ex_mem_size = 2'd0;
  logic [31:0] ex_mem_addr = '0, ex_mem_wdata = '0, ex_mem_result = '0;
  logic [4:0]  ex_mem_rd = '0;
  logic [31:0] memory_dcache_addr, memory_dcache_wdata;
  logic        memory_dcache_read, memory_dcache_write;
  logic [3:0]  memory_dcache_wmask;
  logic [31:0] dcache_memory_rdata = '0;
  logic        dcache_memory_resp = 1'b0;
  logic        mem_wb_valid, mem_wb_ready = 1'b0, mem_wb_we, mem_wb_misaligned;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;

  always #5 clk = ~clk;

  memory_lsu_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_valid(ex_mem_valid), .ex_mem_ready(ex_mem_ready), .ex_mem_op(ex_mem_op),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned), .ex_mem_addr(ex_mem_addr),
    .ex_mem_wdata(ex_mem_wdata), .ex_mem_result(ex_mem_result), .ex_mem_rd(ex_mem_rd),
    .memory_dcache_addr(memory_dcache_addr), .memory_dcache_read(memory_dcache_read),
    .memory_dcache_write(memory_dcache_write), .memory_dcache_wdata(memory_dcache_wdata),
    .memory_dcache_wmask(memory_dcache_wmask), .dcache_memory_rdata(dcache_memory_rdata),
    .dcache_memory_resp(dcache_memory_resp), .mem_wb_valid(mem_wb_valid),
    .mem_wb_ready(mem_wb_ready), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .mem_wb_we(mem_wb_we), .mem_wb_misaligned(mem_wb_misaligned)
  );

`ifdef RVGA_MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct { logic [1:0] op, size; logic uns; logic [31:0] addr, wdata, result; logic [4:0] rd; } op_t;
  typedef struct { logic [31:0] addr, wdata; logic [3:0] wmask; logic load; int off, nb; logic uns; logic [4:0] rd; } req_t;
  typedef struct { logic [31:0] data; logic [4:0] rd; logic we, mis, chk_rd; } out_t;

  op_t  op_q[$];
  req_t req_q[$];
  out_t out_q[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0, resp_cnt = -1, acc_cyc = 0, out_cyc = 0, strobe_cnt = 0;
  int valid_pct = 100, ready_pct = 100, resp_delay = 0, stray_pct = 0;
  bit fix_rdata = 1'b0;
  logic [31:0] rdata_val = '0;
  logic [31:0] last_data = '0, last_req_addr = '0, last_req_wdata = '0;
  logic [4:0]  last_rd = '0;
  logic        last_we = 1'b0, last_mis = 1'b0, last_req_write = 1'b0;
  logic [3:0]  last_req_wmask = '0;
  bit          hold = 1'b0;
  logic [31:0] h_data;
  logic [4:0]  h_rd;
  logic        h_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event seen, required none", name);
  endtask

  function automatic op_t mk(logic [1:0] op, logic [1:0] size, logic uns, logic [31:0] addr,
                             logic [31:0] wdata, logic [31:0] result, logic [4:0] rd);
    op_t o;
    o.op = op; o.size = size; o.uns = uns; o.addr = addr;
    o.wdata = wdata; o.result = result; o.rd = rd;
    return o;
  endfunction

  // Loaded value: take nb bytes starting at byte off, then extend from the top loaded bit.
  function automatic logic [31:0] exp_load(logic [31:0] rdata, int off, int nb, logic uns);
    longint unsigned sh, m;
    sh = 64'(rdata) >> (8 * off);
    if (nb >= 4) return sh[31:0];
    m = (64'd1 << (8 * nb)) - 64'd1;
    if (!uns && (((sh >> (8 * nb - 1)) & 64'd1) == 64'd1)) return 32'((sh & m) | ~m);
    return 32'(sh & m);
  endfunction

  task automatic model_accept(input op_t o);
    int off, nb;
    req_t r;
    off = int'(o.addr[1:0]);
    nb  = 1 << o.size;
    if (o.op == 2'b01 || o.op == 2'b10) begin
      if (TRAP && (o.size == 2'b11 || (off % nb) != 0)) begin
        out_q.push_back('{o.addr, o.rd, 1'b0, 1'b1, 1'b0});
      end else begin
        r.addr = {o.addr[31:2], 2'b00};
        r.wdata = o.wdata << (8 * off);
        r.wmask = 4'(((1 << nb) - 1) << off);
        r.load = (o.op == 2'b01);
        r.off = off; r.nb = nb; r.uns = o.uns; r.rd = o.rd;
        req_q.push_back(r);
      end
    end else begin
      out_q.push_back('{o.result, o.rd, (o.rd != 5'd0), 1'b0, 1'b1});
    end
  endtask

  task automatic monitor();
    out_t o;
    req_t r;
    if (hold) begin
      chk("hold_valid", mem_wb_valid, 1'b1);
      chk("hold_data", mem_wb_data, h_data);
      chk("hold_rd", mem_wb_rd, h_rd);
      chk("hold_we", mem_wb_we, h_we);
    end
    hold = mem_wb_valid && !mem_wb_ready;
    h_data = mem_wb_data; h_rd = mem_wb_rd; h_we = mem_wb_we;
    if (mem_wb_valid) begin
      if (out_q.size() == 0) fail("unexpected_output");
      else if (mem_wb_ready) begin
        o = out_q.pop_front();
        chk("wb_data", mem_wb_data, o.data);
        chk("wb_we", mem_wb_we, o.we);
        chk("wb_misaligned", mem_wb_misaligned, o.mis);
        if (o.chk_rd) chk("wb_rd", mem_wb_rd, o.rd);
        last_data = mem_wb_data; last_rd = mem_wb_rd; last_we = mem_wb_we; last_mis = mem_wb_misaligned;
        out_cyc = cyc;
      end
    end
    if (memory_dcache_read || memory_dcache_write) begin
      strobe_cnt++;
      chk("ready_while_busy", ex_mem_ready, 1'b0);
      if (req_q.size() == 0) fail("unexpected_strobe");
      else begin
        r = req_q[0];
        chk("dc_addr", memory_dcache_addr, r.addr);
        chk("dc_read", memory_dcache_read, r.load);
        chk("dc_write", memory_dcache_write, !r.load);
        if (!r.load) begin
          chk("dc_wdata", memory_dcache_wdata, r.wdata);
          chk("dc_wmask", memory_dcache_wmask, r.wmask);
        end
        last_req_addr = memory_dcache_addr; last_req_write = memory_dcache_write;
        last_req_wdata = memory_dcache_wdata; last_req_wmask = memory_dcache_wmask;
        if (dcache_memory_resp) begin
          void'(req_q.pop_front());
          if (r.load) out_q.push_back('{exp_load(dcache_memory_rdata, r.off, r.nb, r.uns), r.rd, (r.rd != 5'd0), 1'b0, 1'b1});
          else out_q.push_back('{32'd0, r.rd, 1'b0, 1'b0, 1'b0});
        end
      end
    end
    if (ex_mem_valid && ex_mem_ready) begin
      acc_cyc = cyc;
      model_accept(op_q.pop_front());
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (op_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      ex_mem_valid = 1'b1; ex_mem_op = op_q[0].op; ex_mem_size = op_q[0].size;
      ex_mem_unsigned = op_q[0].uns; ex_mem_addr = op_q[0].addr; ex_mem_wdata = op_q[0].wdata;
      ex_mem_result = op_q[0].result; ex_mem_rd = op_q[0].rd;
    end else begin
      ex_mem_valid = 1'b0; ex_mem_op = 2'($urandom); ex_mem_size = 2'($urandom);
      ex_mem_addr = $urandom; ex_mem_wdata = $urandom; ex_mem_result = $urandom; ex_mem_rd = 5'($urandom);
    end
    mem_wb_ready = ($urandom_range(99) < ready_pct);
    dcache_memory_rdata = fix_rdata ? rdata_val : $urandom;
    if (memory_dcache_read || memory_dcache_write) begin
      if (resp_cnt < 0) resp_cnt = (resp_delay < 0) ? int'($urandom_range(3)) : resp_delay;
      dcache_memory_resp = (resp_cnt == 0);
      if (resp_cnt > 0) resp_cnt--;
    end else begin
      resp_cnt = -1;
      dcache_memory_resp = ($urandom_range(99) < stray_pct);
    end
    #4;
    monitor();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((op_q.size() > 0 || req_q.size() > 0 || out_q.size() > 0 || mem_wb_valid) && n < budget) begin
      step();
      n++;
    end
    chk("drain_within_budget", (n < budget), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ex_mem_ready", ex_mem_ready, 1'b1);
    chk("rst_wb_valid", mem_wb_valid, 1'b0);
    chk("rst_wb_we", mem_wb_we, 1'b0);
    chk("rst_wb_mis", mem_wb_misaligned, 1'b0);
    chk("rst_wb_rd", mem_wb_rd, 5'd0);
    chk("rst_wb_data", mem_wb_data, 32'd0);
    chk("rst_dc_read", memory_dcache_read, 1'b0);
    chk("rst_dc_write", memory_dcache_write, 1'b0);
    chk("rst_dc_addr", memory_dcache_addr, 32'd0);
    chk("rst_dc_wdata", memory_dcache_wdata, 32'd0);
    chk("rst_dc_wmask", memory_dcache_wmask, 4'd0);
    rst = 1'b1;

    op_q.push_back(mk(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'h1234, 5'd5));
    run_until_idle(20);
    chk("pass_data", last_data, 32'h1234);
    chk("pass_rd", last_rd, 5'd5);
    chk("pass_we", last_we, 1'b1);
    chk("pass_latency", out_cyc - acc_cyc, 1);

    cyc0 = cyc;
    for (int i = 1; i <= 4; i++) op_q.push_back(mk(2'b11, 2'b00, 1'b0, 32'h0, 32'h0, 32'h100 + i, 5'(i)));
    run_until_idle(20);
    chk("b2b_last_accept", acc_cyc - cyc0, 4);
    chk("b2b_last_data", last_data, 32'h104);

    fix_rdata = 1'b1; rdata_val = 32'h80FF_FFFF; resp_delay = 3;
    op_q.push_back(mk(2'b01, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h0, 5'd9));
    run_until_idle(30);
    chk("lb_dc_addr", last_req_addr, 32'h1000);
    chk("lb_data", last_data, 32'hFFFF_FF80);
    chk("lb_latency", out_cyc - acc_cyc, 5);
    op_q.push_back(mk(2'b01, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h0, 5'd9));
    run_until_idle(30);
    chk("lbu_data", last_data, 32'h0000_0080);
    fix_rdata = 1'b0; resp_delay = 0;

    op_q.push_back(mk(2'b10, 2'b01, 1'b0, 32'h2002, 32'h0000_ABCD, 32'h0, 5'd3));
    run_until_idle(30);
    chk("sh_write", last_req_write, 1'b1);
    chk("sh_dc_addr", last_req_addr, 32'h2000);
    chk("sh_wmask", last_req_wmask, 4'b1100);
    chk("sh_wdata", last_req_wdata, 32'hABCD_0000);
    chk("sh_out_we", last_we, 1'b0);
    chk("sh_latency", out_cyc - acc_cyc, 2);

    ready_pct = 0;
    op_q.push_back(mk(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'h55, 5'd7));
    op_q.push_back(mk(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'h66, 5'd8));
    repeat (4) step();
    chk("bp_valid", mem_wb_valid, 1'b1);
    chk("bp_data", mem_wb_data, 32'h55);
    chk("bp_ex_ready", ex_mem_ready, 1'b0);
    chk("bp_pending_ops", op_q.size(), 1);
    ready_pct = 100;
    step();
    chk("bp_same_edge", acc_cyc, out_cyc);
    chk("bp_drained_data", last_data, 32'h55);
    run_until_idle(20);
    chk("bp_second_data", last_data, 32'h66);

    strobe_cnt = 0;
    op_q.push_back(mk(2'b01, 2'b10, 1'b0, 32'h3001, 32'h0, 32'h0, 5'd4));
    run_until_idle(30);
`ifdef RVGA_MEM_MISALIGN_TRAP_EN
    chk("mis_no_strobe", strobe_cnt, 0);
    chk("mis_flag", last_mis, 1'b1);
    chk("mis_data", last_data, 32'h3001);
    chk("mis_we", last_we, 1'b0);
`else
    chk("mis_issued", (strobe_cnt > 0), 1'b1);
    chk("mis_dc_addr", last_req_addr, 32'h3000);
    chk("mis_is_read", last_req_write, 1'b0);
    chk("mis_flag", last_mis, 1'b0);
`endif

    valid_pct = 70; ready_pct = 60; resp_delay = -1; stray_pct = 20;
    for (int i = 0; i < 400; i++)
      op_q.push_back(mk(2'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom)));
    run_until_idle(6000);

    valid_pct = 100; ready_pct = 100; resp_delay = 50; stray_pct = 0;
    op_q.push_back(mk(2'b01, 2'b10, 1'b0, 32'h4000, 32'h0, 32'h0, 5'd6));
    for (int i = 0; i < 6 && !memory_dcache_read; i++) step();
    chk("rst_mid_read_before", memory_dcache_read, 1'b1);
    #3 rst = 1'b0;
    #1;
    chk("rst_mid_read_async", memory_dcache_read, 1'b0);
    chk("rst_mid_valid_async", mem_wb_valid, 1'b0);
    chk("rst_mid_ex_ready", ex_mem_ready, 1'b1);
    op_q.delete(); req_q.delete(); out_q.delete();
    hold = 1'b0; resp_cnt = -1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    stray_pct = 100;
    repeat (5) step();
    chk("stray_resp_no_valid", mem_wb_valid, 1'b0);
    chk("stray_resp_no_strobe", memory_dcache_read, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/memory_lsu_stage.md
# memory_lsu_stage

Parametrised memory stage for the rvga pipeline. It sits between execute and writeback and replaces the stubbed memory stage. It performs byte, half, word and (for XLEN=64) double loads and stores through the dcache handshake, with byte-lane masking and sign/zero extension. It passes non-memory results straight through a one-entry output register and exerts valid/ready backpressure on both sides.

## Interface
- XLEN, 32: data/address width; legal values 32 or 64.
- NB = XLEN/8 (derived, not overridable); OFFW = log2(NB).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- ex_mem_valid  in  1  execute offers an op.
- ex_mem_ready  out  1  stage accepts the op this cycle.
- ex_mem_op  in  2  00 none (passthrough), 01 load, 10 store, 11 reserved (treated as none).
- ex_mem_size  in  2  00 byte, 01 half, 10 word, 11 double (XLEN=64 only).
- ex_mem_unsigned  in  1  zero-extend load.
- ex_mem_addr  in  XLEN  effective address.
- ex_mem_wdata  in  XLEN  store data, low-aligned.
- ex_mem_result  in  XLEN  ALU result for passthrough.
- ex_mem_rd  in  5  destination register.
- memory_dcache_addr  out  XLEN  NB-aligned address (low OFFW bits 0).
- memory_dcache_read / memory_dcache_write  out  1  request strobes.
- memory_dcache_wdata  out  XLEN  lane-shifted store data.
- memory_dcache_wmask  out  NB  byte enables for stores.
- dcache_memory_rdata  in  XLEN  load data.
- dcache_memory_resp  in  1  request complete.
- mem_wb_valid  out  1; mem_wb_ready  in  1.
- mem_wb_rd  out  5; mem_wb_data  out  XLEN; mem_wb_we  out  1.
- mem_wb_misaligned  out  1  misaligned-access flag.

## Operation
- FSM states: IDLE, ACCESS.
- ex_mem_ready = (state==IDLE) && (!mem_wb_valid || mem_wb_ready). Accept = ex_mem_valid && ex_mem_ready.
- IDLE, accept, op none: the output register loads {rd, result, we=(rd!=0)} and mem_wb_valid=1.
- IDLE, accept, load/store: the request registers load, state goes to ACCESS, and mem_wb_valid goes to 0 (the old entry drains on the same edge).
- ACCESS: read (load) or write (store) is held high. addr, wdata and wmask are held constant until a resp is sampled.
- ACCESS, resp=1: state goes to IDLE and the strobes drop.
  - Load: output gets the extended data with we=(rd!=0).
  - Store: output gets we=0, data=0.
- Lane math: off = addr[OFFW-1:0]; bytes = 1<<size.
  - wmask = ((1<<bytes)-1)<<off, truncated to NB bits.
  - wdata = ex_mem_wdata << (8*off).
  - Load: shifted = rdata >> (8*off), then sign- or zero-extended from bit 8*bytes-1.
  - Word with XLEN=32 is not extended.
- size 11 with XLEN=32 is treated as misaligned.
- resp in IDLE is ignored.
- mem_wb_valid is held with stable contents while mem_wb_ready=0.

## Timing
- Reset values: state IDLE; mem_wb_valid, we, misaligned 0; rd, data 0; dcache addr, wdata, wmask 0; read and write 0. ex_mem_ready=1 right after reset.
- Dcache outputs are registered. For a request accepted at edge 0, the strobe is visible in cycle 1.
- A resp sampled at edge k gives mem_wb_valid=1 and ex_mem_ready=1 in cycle k+1. Minimum load/store latency is 2 cycles.
- Passthrough latency is 1 cycle, with throughput of one per cycle when mem_wb_ready=1.
- Reset asserted mid-ACCESS clears the strobes and output valid immediately (asynchronous). A resp arriving after release is ignored.
- The stage keeps at most one outstanding dcache request.

## Configuration
- RVGA_MEM_MISALIGN_TRAP_EN defined:
  - An access where off is not a multiple of bytes (or size 11 with XLEN=32) is never issued to the dcache.
  - The output loads next cycle with we=0, data=addr, mem_wb_misaligned=1, and state stays IDLE.
- Undefined:
  - Misaligned accesses are issued anyway, with mask and data truncated to the aligned NB-byte word (bytes past the boundary are dropped).
  - mem_wb_misaligned is tied to 0.

## Test plan
- Passthrough: XLEN=32, op none, rd=5, result=0x1234 with mem_wb_ready=1 -> next cycle valid, rd=5, data=0x1234, we=1. Back-to-back ops accepted every cycle.
- Signed byte load: addr 0x1003, rdata 0x80FFFFFF, resp after 3 cycles -> dcache addr 0x1000, data 0xFFFFFF80. The same load with unsigned=1 -> 0x00000080.
- Half store: addr 0x2002, wdata 0xABCD -> write=1, addr 0x2000, wmask 4'b1100, wdata 0xABCD0000. Output we=0 after resp.
- Backpressure: mem_wb_ready=0 with valid output -> ex_mem_ready=0 and output stable. Raising ready lets the next op accept on the same edge.
- Misaligned word load at 0x3001:
  - Macro on: no read strobe, misaligned=1, data=0x3001.
  - Macro off: read issued at 0x3000.
- Reset mid-ACCESS: drive rst=0 while read=1 -> read drops without waiting for a clock. After release, a stray resp gives no mem_wb_valid.
